// File: rtl/dcsk_pkg.sv
// Shared types and constants for the DCSK burst transmitter.
package dcsk_pkg;

  typedef enum logic [1:0] {
    SF2  = 2'd0,
    SF4  = 2'd1,
    SF8  = 2'd2,
    SF16 = 2'd3
  } sf_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } tx_state_t;

  localparam logic [31:0] LFSR_DEFAULT_TAPS = 32'h8020_0003;

  // One reference burst plus one data burst per message bit.
  function automatic int unsigned chips_per_msg(input int unsigned msg_w, input int unsigned sf);
    return msg_w * 2 * (32'd2 << sf);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dcsk_burst_tx.sv
// DCSK transmitter: queued messages are spread MSB-first into reference/data chip bursts
// driven from a free-running Galois LFSR, back-to-back with no idle gap.
module dcsk_burst_tx import dcsk_pkg::*; #(
  parameter int                 MSG_W      = 32,
  parameter int                 SF_W       = 2,
  parameter int                 FIFO_DEPTH = 4,
  parameter int                 LFSR_W     = 32,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS  = LFSR_W'(LFSR_DEFAULT_TAPS)
) (
  input  logic                            i_clk,
  input  logic                            i_arst_n,
  input  logic [LFSR_W-1:0]               i_seed,
  input  logic                            i_load_seed,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [MSG_W-1:0]                i_msg,
  input  logic [SF_W-1:0]                 i_sf,
  output logic                            o_tx,
  output logic                            o_is_sending,
  output logic                            o_msg_done,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count
);

  localparam int CNT_W  = 2 ** SF_W;
  localparam int SF_MAX = 2 ** CNT_W;
  localparam int BIT_W  = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam int FW     = MSG_W + SF_W;

  tx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_last;
  logic [BIT_W-1:0]   bit_idx, bit_nxt;
  logic [MSG_W-1:0]   msg_q;
  logic [SF_W-1:0]    sf_q;
  logic [SF_MAX-1:0]  ref_buf;
  logic [LFSR_W-1:0]  lfsr, lfsr_step;
  logic               tx_q;
  logic               chip_nxt;
  logic               pop;
  logic               msg_done;
  logic               seed_ok;
  logic [FW-1:0]      fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gclk   (i_clk),
    .grst_n (i_arst_n),
    .push   (i_valid),
    .pop    (pop),
    .wdata  ({i_msg, i_sf}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (o_fifo_count)
  );

  // Last chip index of a burst: SF-1 with SF = 2^(sf+1).
  assign cnt_last  = CNT_W'((1 << (int'(sf_q) + 1)) - 1);
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign seed_ok   = i_load_seed && (state == IDLE) && fifo_empty;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = REF;
          cnt_nxt   = '0;
          bit_nxt   = BIT_W'(MSG_W - 1);
        end
      end
      REF: begin
        if (cnt == cnt_last) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt != cnt_last) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = '0;
          if (bit_idx != '0) begin
            state_nxt = REF;
            bit_nxt   = bit_idx - 1'b1;
          end else if (!fifo_empty) begin
            state_nxt = REF;
            bit_nxt   = BIT_W'(MSG_W - 1);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Chip for the state being entered; registered so o_tx lines up with state/counters.
  always_comb begin
    msg_done = (state == DATA) && (cnt == cnt_last) && (bit_idx == '0);
    pop      = !fifo_empty && ((state == IDLE) || msg_done);
    chip_nxt = 1'b0;
    if (state_nxt == REF)
      chip_nxt = lfsr[0];
    else if (state_nxt == DATA)
      chip_nxt = ref_buf[cnt_nxt] ^ ~msg_q[bit_nxt];
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      msg_q   <= '0;
      sf_q    <= '0;
      lfsr    <= '1;
      ref_buf <= '0;
      tx_q    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      tx_q    <= chip_nxt;
      if (pop) begin
        msg_q <= fifo_rdata[FW-1:SF_W];
        sf_q  <= fifo_rdata[SF_W-1:0];
      end
      // A zero seed would lock the LFSR, so it maps to all-ones.
      if (seed_ok) begin
        lfsr <= (i_seed == '0) ? '1 : i_seed;
      end else if (state_nxt == REF) begin
        lfsr             <= lfsr_step;
        ref_buf[cnt_nxt] <= lfsr[0];
      end
    end
  end

  assign o_tx         = tx_q;
  assign o_is_sending = (state != IDLE);
  assign o_msg_done   = msg_done;
  assign o_ready      = !fifo_full;

endmodule

// File: tb/tb_dcsk_burst_tx.sv
// Scoreboard bench for dcsk_burst_tx: a negedge monitor frames and demodulates chips,
// scenario tasks push expectations and compare completed messages.
module tb_dcsk_burst_tx;
  import dcsk_pkg::*;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        i_clk;
  logic        i_arst_n;
  logic [31:0] i_seed;
  logic        i_load_seed;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_msg;
  logic [1:0]  i_sf;
  logic        o_tx;
  logic        o_is_sending;
  logic        o_msg_done;
  logic [2:0]  o_fifo_count;

  dcsk_burst_tx dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_seed       (i_seed),
    .i_load_seed  (i_load_seed),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_msg        (i_msg),
    .i_sf         (i_sf),
    .o_tx         (o_tx),
    .o_is_sending (o_is_sending),
    .o_msg_done   (o_msg_done),
    .o_fifo_count (o_fifo_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] msg; int sf; } exp_t;
  typedef struct {
    logic [31:0] msg; logic [31:0] rec; int sf; int len; int ref_err; int burst_err; int ones;
  } res_t;

  exp_t exp_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // monitor state
  logic [31:0] m_lfsr = '1;
  logic [15:0] refb;
  logic [31:0] rec;
  logic        ebit;
  exp_t        cur;
  res_t        mr;
  bit          active = 0;
  int idx, agree, ref_err, burst_err, ones, sfn, pos, bn;
  int run_len = 0, last_run = 0, idle_tx_err = 0, unexpected = 0;

  always @(negedge i_clk) begin
    if (!i_arst_n) begin
      active = 0; m_lfsr = '1; run_len = 0;
      exp_q.delete();
    end else if (!o_is_sending) begin
      if (o_tx !== 1'b0) idle_tx_err++;
      if (run_len > 0) last_run = run_len;
      run_len = 0;
      active = 0;
    end else begin
      run_len++;
      if (!active) begin
        if (exp_q.size() == 0) unexpected++;
        else begin
          cur = exp_q.pop_front(); active = 1;
          idx = 0; agree = 0; ref_err = 0; burst_err = 0; ones = 0; rec = '0;
        end
      end
      if (active) begin
        sfn = 2 << cur.sf;
        pos = idx % (2 * sfn);
        bn  = idx / (2 * sfn);
        if (pos < sfn) begin
          if (o_tx !== m_lfsr[0]) ref_err++;
          if (o_tx === 1'b1) ones++;
          refb[pos] = o_tx;
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
        end else begin
          ebit = (bn < 32) ? cur.msg[31 - bn] : 1'b0;
          if (o_tx !== (refb[pos - sfn] ^ ~ebit)) burst_err++;
          if (o_tx === refb[pos - sfn]) agree++;
          if (pos == 2 * sfn - 1) begin
            rec = {rec[30:0], (agree > sfn / 2)};
            agree = 0;
          end
        end
        if (o_msg_done === 1'b1) begin
          mr.msg = cur.msg; mr.rec = rec; mr.sf = cur.sf; mr.len = idx + 1;
          mr.ref_err = ref_err; mr.burst_err = burst_err; mr.ones = ones;
          res_q.push_back(mr);
          active = 0;
        end
        idx++;
      end
    end
  end

  // Caller is at a negedge; returns at the following negedge.
  task automatic push(input logic [31:0] msg, input sf_t sf, input bit expect_accept);
    exp_t e;
    i_msg = msg; i_sf = sf; i_valid = 1'b1;
    if (expect_accept) begin
      e.msg = msg; e.sf = int'(sf);
      exp_q.push_back(e);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    i_seed = s; i_load_seed = 1'b1;
    @(negedge i_clk);
    i_load_seed = 1'b0;
    m_lfsr = (s == 0) ? '1 : s;
  endtask

  task automatic get_result(output res_t r, output bit got);
    got = 0;
    r = '{default: 0};
    for (int i = 0; i < 4000; i++) begin
      if (res_q.size() > 0) begin
        r = res_q.pop_front(); got = 1; break;
      end
      @(negedge i_clk);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: no message completed within 4000 cycles");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge i_clk); n++; end while (o_msg_done !== 1'b1 && n < 3000);
    if (o_msg_done !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: o_msg_done not seen within 3000 cycles");
    end
  endtask

  task automatic wait_sending();
    int n = 0;
    while (o_is_sending !== 1'b1 && n < 100) begin @(negedge i_clk); n++; end
    if (o_is_sending !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: o_is_sending not seen within 100 cycles");
    end
  endtask

  task automatic test_reset();
    i_arst_n = 1'b0; i_seed = '0; i_load_seed = 0; i_valid = 0; i_msg = '0; i_sf = '0;
    repeat (3) @(negedge i_clk);
    n_checks += 5;
    if (o_tx !== 1'b0)         begin n_fail++; $display("FAIL reset_tx: got %b expected 0", o_tx); end
    if (o_is_sending !== 1'b0) begin n_fail++; $display("FAIL reset_sending: got %b expected 0", o_is_sending); end
    if (o_msg_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_msg_done); end
    if (o_ready !== 1'b1)      begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_fifo_count); end
    i_arst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_ones_sf2();
    res_t r; bit got;
    load_seed(32'h1);
    push(32'hFFFF_FFFF, SF2, 1);
    get_result(r, got);
    if (got) begin
      n_checks += 4;
      if (r.len !== 128)     begin n_fail++; $display("FAIL ones_len: got %0d expected 128", r.len); end
      if (r.burst_err !== 0) begin n_fail++; $display("FAIL ones_repeat: %0d data chips differ from reference, expected 0", r.burst_err); end
      if (r.ref_err !== 0)   begin n_fail++; $display("FAIL ones_ref_chips: %0d ref chips off lfsr, expected 0", r.ref_err); end
      if (r.rec !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ones_demod: got %h expected ffffffff", r.rec); end
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_zeros_sf16();
    res_t r; bit got;
    push(32'h0, SF16, 1);
    get_result(r, got);
    if (got) begin
      n_checks += 4;
      if (r.len !== 1024)    begin n_fail++; $display("FAIL zeros_len: got %0d expected 1024", r.len); end
      if (r.burst_err !== 0) begin n_fail++; $display("FAIL zeros_invert: %0d data chips not inverted, expected 0", r.burst_err); end
      if (r.ref_err !== 0)   begin n_fail++; $display("FAIL zeros_ref_chips: %0d ref chips off lfsr, expected 0", r.ref_err); end
      if (r.rec !== 32'h0)   begin n_fail++; $display("FAIL zeros_demod: got %h expected 00000000", r.rec); end
    end
    repeat (3) @(negedge i_clk);
  endtask

  // One message goes straight on air, four more fill the queue.
  task automatic test_queue_full();
    res_t r; bit got;
    push(32'hA5C3_0F96, SF2, 1);
    push(32'h1357_9BDF, SF2, 1);
    push(32'h8421_4812, SF4, 1);
    push(32'hF0E1_D2C3, SF8, 1);
    push(32'h6B2D_97E4, SF16, 1);
    n_checks += 2;
    if (o_ready !== 1'b0)      begin n_fail++; $display("FAIL full_ready: got %b expected 0", o_ready); end
    if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", o_fifo_count); end
    push(32'hDEAD_DEAD, SF2, 0);
    n_checks++;
    if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL reject_count: got %0d expected 4", o_fifo_count); end
    repeat (20) @(negedge i_clk);
    n_checks++;
    if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL hold_count: got %0d expected 4", o_fifo_count); end
    wait_done();
    n_checks++;
    if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL prepop_count: got %0d expected 4", o_fifo_count); end
    @(negedge i_clk);
    n_checks++;
    if (o_fifo_count !== 3'd3) begin n_fail++; $display("FAIL pop_count: got %0d expected 3", o_fifo_count); end
    wait_done();
    push(32'h0F0F_3C3C, SF2, 1);
    n_checks++;
    if (o_fifo_count !== 3'd3) begin n_fail++; $display("FAIL pushpop_count: got %0d expected 3", o_fifo_count); end
    for (int m = 0; m < 6; m++) begin
      get_result(r, got);
      if (got) begin
        n_checks += 4;
        if (r.len !== 64 * (2 << r.sf)) begin n_fail++; $display("FAIL q%0d_len: got %0d expected %0d", m, r.len, 64 * (2 << r.sf)); end
        if (r.rec !== r.msg)   begin n_fail++; $display("FAIL q%0d_demod: got %h expected %h", m, r.rec, r.msg); end
        if (r.ref_err !== 0)   begin n_fail++; $display("FAIL q%0d_ref_chips: %0d off lfsr, expected 0", m, r.ref_err); end
        if (r.burst_err !== 0) begin n_fail++; $display("FAIL q%0d_data_chips: %0d wrong, expected 0", m, r.burst_err); end
      end
    end
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (last_run !== 2176) begin n_fail++; $display("FAIL continuous_run: got %0d sending cycles expected 2176", last_run); end
  endtask

  task automatic test_seed_zero();
    res_t r; bit got;
    load_seed(32'h0);
    push(32'h1234_5678, SF4, 1);
    get_result(r, got);
    if (got) begin
      n_checks += 3;
      if (r.ref_err !== 0) begin n_fail++; $display("FAIL seed0_ref_chips: %0d off all-ones lfsr, expected 0", r.ref_err); end
      if (!(r.ones > 0 && r.ones < 128)) begin n_fail++; $display("FAIL seed0_nonconst: got %0d ones of 128 expected between", r.ones); end
      if (r.rec !== 32'h1234_5678) begin n_fail++; $display("FAIL seed0_demod: got %h expected 12345678", r.rec); end
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_seed_busy();
    res_t r; bit got;
    push(32'hCAFE_F00D, SF8, 1);
    wait_sending();
    repeat (10) @(negedge i_clk);
    i_seed = 32'hDEAD_BEEF; i_load_seed = 1'b1;
    @(negedge i_clk);
    i_load_seed = 1'b0;
    get_result(r, got);
    if (got) begin
      n_checks += 3;
      if (r.ref_err !== 0)   begin n_fail++; $display("FAIL busyseed_ref_chips: %0d off lfsr, expected 0", r.ref_err); end
      if (r.burst_err !== 0) begin n_fail++; $display("FAIL busyseed_data_chips: %0d wrong, expected 0", r.burst_err); end
      if (r.rec !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL busyseed_demod: got %h expected cafef00d", r.rec); end
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    res_t r; bit got;
    push(32'h5555_AAAA, SF2, 1);
    push(32'h7777_1111, SF2, 1);
    wait_sending();
    repeat (49) @(negedge i_clk);
    n_checks++;
    if (o_fifo_count !== 3'd1) begin n_fail++; $display("FAIL midmsg_count: got %0d expected 1", o_fifo_count); end
    i_arst_n = 1'b0;
    #1;
    n_checks += 4;
    if (o_tx !== 1'b0)         begin n_fail++; $display("FAIL abort_tx: got %b expected 0", o_tx); end
    if (o_is_sending !== 1'b0) begin n_fail++; $display("FAIL abort_sending: got %b expected 0", o_is_sending); end
    if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL abort_count: got %0d expected 0", o_fifo_count); end
    if (o_ready !== 1'b1)      begin n_fail++; $display("FAIL abort_ready: got %b expected 1", o_ready); end
    repeat (2) @(negedge i_clk);
    i_arst_n = 1'b1;
    @(negedge i_clk);
    push(32'h3C5A_96E1, SF4, 1);
    get_result(r, got);
    if (got) begin
      n_checks += 3;
      if (r.len !== 256)   begin n_fail++; $display("FAIL postreset_len: got %0d expected 256", r.len); end
      if (r.ref_err !== 0) begin n_fail++; $display("FAIL postreset_ref_chips: %0d off all-ones lfsr, expected 0", r.ref_err); end
      if (r.rec !== 32'h3C5A_96E1) begin n_fail++; $display("FAIL postreset_demod: got %h expected 3c5a96e1", r.rec); end
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_idle_behaviour();
    n_checks += 3;
    if (idle_tx_err !== 0) begin n_fail++; $display("FAIL idle_tx: %0d cycles with o_tx=1 while idle, expected 0", idle_tx_err); end
    if (unexpected !== 0)  begin n_fail++; $display("FAIL unexpected_send: %0d chips with nothing queued, expected 0", unexpected); end
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL leftover: %0d messages never sent, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_ones_sf2();
    test_zeros_sf16();
    test_queue_full();
    test_seed_zero();
    test_seed_busy();
    test_reset_mid();
    test_idle_behaviour();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
